branch_resolver: RTL and testbench

Resolution side of the BTB/BHT branch predictor: tracks each fetched instruction's predicted next PC through ID and EX and compares it with the real control-flow outcome. It drives the predictor's write port (tag/target install, 2-bit counter update) and issues redirect and flush requests to the fetch and pipeline control logic. It sits between the predictor and the ID/EX stages of the 16-bit pipelined CPU.

---
 rtl/branch_resolver_pkg.sv | 15 +
 rtl/branch_resolver_if.sv | 51 +++++
 rtl/branch_slot.sv | 41 ++++
 rtl/branch_resolver.sv | 122 ++++++++++++
 tb/tb_branch_resolver.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared constants and the tracking-slot record for the branch predictor and its resolver.
package branch_resolver_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int BTB_IDX_SIZE = 8;

  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] npc_pred;
    logic                 tag_match;
    logic                 is_branch;
  } slot_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline/predictor-facing signal bundle of branch_resolver; master is the pipeline side.
interface branch_resolver_if
  import branch_resolver_pkg::*;
();

  logic                 stall;
  logic                 if_valid;
  logic [WORD_SIZE-1:0] if_pc;
  logic [WORD_SIZE-1:0] if_npc_pred;
  logic                 if_tag_match;
  logic                 id_is_branch;
  logic                 id_is_jump;
  logic                 id_is_jpr;
  logic [WORD_SIZE-1:0] id_target;
  logic                 ex_taken;
  logic [WORD_SIZE-1:0] ex_target;

  logic                 update_tag;
  logic [WORD_SIZE-1:0] pc_collided;
  logic [WORD_SIZE-1:0] branch_target;
  logic                 update_bht;
  logic [WORD_SIZE-1:0] pc_outcome;
  logic                 branch_outcome;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 flush_if;
  logic                 flush_id;
  logic [15:0]          stat_branches;
  logic [15:0]          stat_mispredicts;

  modport master (
    output stall, if_valid, if_pc, if_npc_pred, if_tag_match,
           id_is_branch, id_is_jump, id_is_jpr, id_target,
           ex_taken, ex_target,
    input  update_tag, pc_collided, branch_target,
           update_bht, pc_outcome, branch_outcome,
           redirect_valid, redirect_pc, flush_if, flush_id,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  stall, if_valid, if_pc, if_npc_pred, if_tag_match,
           id_is_branch, id_is_jump, id_is_jpr, id_target,
           ex_taken, ex_target,
    output update_tag, pc_collided, branch_target,
           update_bht, pc_outcome, branch_outcome,
           redirect_valid, redirect_pc, flush_if, flush_id,
           stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/branch_slot.sv
// One prediction-tracking slot: holds its contents while stalled, valid bit cleared by reset.
module branch_slot
  import branch_resolver_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  slot_t slot_d,
    output slot_t slot_q
);

    logic                 valid_p0;
    logic [WORD_SIZE-1:0] pc_p0;
    logic [WORD_SIZE-1:0] npc_pred_p0;
    logic                 tag_match_p0;
    logic                 is_branch_p0;

    always_ff @(posedge clk) begin
        if (reset)
            valid_p0 <= 1'b0;
        else if (!stall)
            valid_p0 <= slot_d.valid;
    end

    // Payload carries no reset; it is only meaningful while valid_p0 is set.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pc_p0        <= slot_d.pc;
            npc_pred_p0  <= slot_d.npc_pred;
            tag_match_p0 <= slot_d.tag_match;
            is_branch_p0 <= slot_d.is_branch;
        end
    end

    assign slot_q = '{valid:     valid_p0,
                      pc:        pc_p0,
                      npc_pred:  npc_pred_p0,
                      tag_match: tag_match_p0,
                      is_branch: is_branch_p0};

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted next-PCs in ID and EX, drives predictor updates, redirects and flushes.
// Optional statistics counters are built when BRANCH_RESOLVER_STATS_EN is defined.
module branch_resolver
  import branch_resolver_pkg::*;
(
    input logic         clk,
    input logic         reset,
    branch_resolver_if.slave br
);

    slot_t id_d, id_q;
    slot_t ex_d, ex_q;

    logic                 live;
    logic                 ex_res, ex_mis;
    logic [WORD_SIZE-1:0] ex_actual;
    logic                 id_ctl, id_live, id_res, id_mis, id_inst;
    logic                 redirect, flush_if_w, flush_id_w;

    // Slot-advance inputs
    always_comb begin
        id_d           = '0;
        id_d.valid     = br.if_valid & ~flush_if_w;
        id_d.pc        = br.if_pc;
        id_d.npc_pred  = br.if_npc_pred;
        id_d.tag_match = br.if_tag_match;
        id_d.is_branch = 1'b0;

        ex_d           = id_q;
        ex_d.valid     = id_q.valid & ~flush_id_w & br.id_is_branch;
        ex_d.is_branch = br.id_is_branch;
    end

    branch_slot u_id_slot (
        .clk    (clk),
        .reset  (reset),
        .stall  (br.stall),
        .slot_d (id_d),
        .slot_q (id_q)
    );

    branch_slot u_ex_slot (
        .clk    (clk),
        .reset  (reset),
        .stall  (br.stall),
        .slot_d (ex_d),
        .slot_q (ex_q)
    );

    logic unused_slot_bits;
    assign unused_slot_bits = ex_q.tag_match ^ id_q.is_branch;

    // Resolution: EX has priority; an EX mispredict squashes everything from ID
    always_comb begin
        live      = ~reset & ~br.stall;
        ex_res    = live & ex_q.valid & ex_q.is_branch;
        ex_actual = br.ex_taken ? br.ex_target : ex_q.pc + WORD_SIZE'(1);
        ex_mis    = ex_res & (ex_q.npc_pred != ex_actual);

        id_live   = live & id_q.valid & ~ex_mis;
        id_ctl    = br.id_is_jump | br.id_is_jpr;
        id_res    = id_live & id_ctl;
        id_mis    = id_res & (id_q.npc_pred != br.id_target);
        id_inst   = id_live & (br.id_is_branch | id_ctl) & ~id_q.tag_match;

        redirect   = ex_mis | id_mis;
        flush_if_w = redirect;
        flush_id_w = ex_mis;
    end

    always_comb begin
        br.update_tag     = id_inst;
        br.pc_collided    = id_inst ? id_q.pc : '0;
        br.branch_target  = id_inst ? br.id_target : '0;

        br.update_bht     = ex_res | id_res;
        br.pc_outcome     = '0;
        br.branch_outcome = 1'b0;
        if (ex_res) begin
            br.pc_outcome     = ex_q.pc;
            br.branch_outcome = br.ex_taken;
        end else if (id_res) begin
            br.pc_outcome     = id_q.pc;
            br.branch_outcome = 1'b1;
        end

        br.redirect_valid = redirect;
        br.redirect_pc    = ex_mis ? ex_actual : (id_mis ? br.id_target : '0);
        br.flush_if       = flush_if_w;
        br.flush_id       = flush_id_w;
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] stat_br_p0, stat_mis_p0;
    logic [1:0]  br_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign br_inc = {1'b0, ex_res} + {1'b0, id_res};

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_p0  <= '0;
            stat_mis_p0 <= '0;
        end else begin
            stat_br_p0  <= sat_inc(stat_br_p0, br_inc);
            stat_mis_p0 <= sat_inc(stat_mis_p0, {1'b0, redirect});
        end
    end

    assign br.stat_branches    = stat_br_p0;
    assign br.stat_mispredicts = stat_mis_p0;
`else
    assign br.stat_branches    = '0;
    assign br.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed pulses, redirects and statistics.
module tb_branch_resolver;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef BRANCH_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_resolver_if bus ();

    branch_resolver dut (
        .clk   (clk),
        .reset (reset),
        .br    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic t, input logic b,
                              input logic r, input logic fi, input logic fd);
        chk({tag, ".update_tag"},     {31'b0, bus.update_tag},     {31'b0, t});
        chk({tag, ".update_bht"},     {31'b0, bus.update_bht},     {31'b0, b});
        chk({tag, ".redirect_valid"}, {31'b0, bus.redirect_valid}, {31'b0, r});
        chk({tag, ".flush_if"},       {31'b0, bus.flush_if},       {31'b0, fi});
        chk({tag, ".flush_id"},       {31'b0, bus.flush_id},       {31'b0, fd});
    endtask

    task automatic chk_stats(input string tag, input int nb, input int nm);
        chk({tag, ".stat_branches"},    {16'b0, bus.stat_branches},    STATS ? nb : 0);
        chk({tag, ".stat_mispredicts"}, {16'b0, bus.stat_mispredicts}, STATS ? nm : 0);
    endtask

    task automatic set_if(input logic v, input logic [15:0] pc, input logic [15:0] npc, input logic tm);
        bus.if_valid     = v;
        bus.if_pc        = pc;
        bus.if_npc_pred  = npc;
        bus.if_tag_match = tm;
    endtask

    task automatic set_id(input logic b, input logic j, input logic r, input logic [15:0] tgt);
        bus.id_is_branch = b;
        bus.id_is_jump   = j;
        bus.id_is_jpr    = r;
        bus.id_target    = tgt;
    endtask

    task automatic set_ex(input logic tk, input logic [15:0] tgt);
        bus.ex_taken  = tk;
        bus.ex_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        reset     = 1'b1;
        bus.stall = 1'b0;
        set_if(1'b0, 16'h0, 16'h0, 1'b0);
        set_id(1'b0, 1'b0, 1'b0, 16'h0);
        set_ex(1'b0, 16'h0);

        step(); settle();
        chk_pulses("reset0", 0, 0, 0, 0, 0);
        chk_stats("reset0", 0, 0);

        // reset overrides stall and decode activity
        step(); bus.stall = 1'b1; set_if(1'b1, 16'h0005, 16'h0006, 1'b0); set_id(1'b0, 1'b1, 1'b0, 16'h0077); settle();
        chk_pulses("reset1", 0, 0, 0, 0, 0);

        // jump at 0x0010 mispredicted in ID, no tag hit
        step(); reset = 1'b0; bus.stall = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 16'h0); set_if(1'b1, 16'h0010, 16'h0011, 1'b0); settle();
        chk_pulses("c1", 0, 0, 0, 0, 0);

        step(); set_if(1'b1, 16'h0011, 16'h0012, 1'b1); set_id(1'b0, 1'b1, 1'b0, 16'h0040); settle();
        chk_pulses("id_jump", 1, 1, 1, 1, 0);
        chk("id_jump.pc_collided",    {16'b0, bus.pc_collided},    32'h0010);
        chk("id_jump.branch_target",  {16'b0, bus.branch_target},  32'h0040);
        chk("id_jump.redirect_pc",    {16'b0, bus.redirect_pc},    32'h0040);
        chk("id_jump.pc_outcome",     {16'b0, bus.pc_outcome},     32'h0010);
        chk("id_jump.branch_outcome", {31'b0, bus.branch_outcome}, 32'h1);

        step(); set_if(1'b1, 16'h0020, 16'h0030, 1'b1); settle();
        chk_pulses("id_jump_once", 0, 0, 0, 0, 0);
        chk_stats("after_jump", 1, 1);

        // branch at 0x0020 correctly predicted taken
        step(); set_if(1'b1, 16'h0030, 16'h0031, 1'b1); set_id(1'b1, 1'b0, 1'b0, 16'h0030); settle();
        chk_pulses("br_in_id", 0, 0, 0, 0, 0);

        step(); set_id(1'b0, 1'b0, 1'b0, 16'h0); set_ex(1'b1, 16'h0030); set_if(1'b1, 16'h0020, 16'h0030, 1'b1); settle();
        chk_pulses("ex_taken_ok", 0, 1, 0, 0, 0);
        chk("ex_taken_ok.pc_outcome",     {16'b0, bus.pc_outcome},     32'h0020);
        chk("ex_taken_ok.branch_outcome", {31'b0, bus.branch_outcome}, 32'h1);

        // same branch not taken, untagged jump sits behind it in ID
        step(); set_if(1'b1, 16'h0030, 16'h0031, 1'b0); set_id(1'b1, 1'b0, 1'b0, 16'h0030); settle();
        chk_pulses("c6", 0, 0, 0, 0, 0);
        chk_stats("c6", 2, 1);

        step(); set_id(1'b0, 1'b1, 1'b0, 16'h0050); set_ex(1'b0, 16'h0030); set_if(1'b1, 16'h0031, 16'h0032, 1'b1); settle();
        chk_pulses("ex_mispred", 0, 1, 1, 1, 1);
        chk("ex_mispred.redirect_pc",    {16'b0, bus.redirect_pc},    32'h0021);
        chk("ex_mispred.pc_outcome",     {16'b0, bus.pc_outcome},     32'h0020);
        chk("ex_mispred.branch_outcome", {31'b0, bus.branch_outcome}, 32'h0);

        step(); set_if(1'b1, 16'h0060, 16'h0061, 1'b1); set_id(1'b0, 1'b0, 1'b0, 16'h0); settle();
        chk_pulses("after_ex_flush", 0, 0, 0, 0, 0);
        chk_stats("c8", 3, 2);

        // branch at 0x0060 reaches EX, then stalled for three cycles
        step(); set_if(1'b0, 16'h0, 16'h0, 1'b0); set_id(1'b1, 1'b0, 1'b0, 16'h0080); settle();
        chk_pulses("c9", 0, 0, 0, 0, 0);

        step(); bus.stall = 1'b1; set_id(1'b0, 1'b0, 1'b0, 16'h0); set_ex(1'b1, 16'h0080); settle();
        chk_pulses("stall1", 0, 0, 0, 0, 0);
        step(); settle();
        chk_pulses("stall2", 0, 0, 0, 0, 0);
        step(); settle();
        chk_pulses("stall3", 0, 0, 0, 0, 0);

        step(); bus.stall = 1'b0; settle();
        chk_pulses("stall_release", 0, 1, 1, 1, 1);
        chk("stall_release.pc_outcome",  {16'b0, bus.pc_outcome},  32'h0060);
        chk("stall_release.redirect_pc", {16'b0, bus.redirect_pc}, 32'h0080);

        // not-taken branch at 0xFFFF wraps to 0x0000
        step(); set_if(1'b1, 16'hFFFF, 16'h1234, 1'b1); set_ex(1'b0, 16'h0); settle();
        chk_pulses("after_release", 0, 0, 0, 0, 0);
        chk_stats("c14", 4, 3);

        step(); set_if(1'b0, 16'h0, 16'h0, 1'b0); set_id(1'b1, 1'b0, 1'b0, 16'h1234); settle();
        chk_pulses("c15", 0, 0, 0, 0, 0);

        step(); set_id(1'b0, 1'b0, 1'b0, 16'h0); set_ex(1'b0, 16'h1234); settle();
        chk_pulses("wrap", 0, 1, 1, 1, 1);
        chk("wrap.redirect_pc", {16'b0, bus.redirect_pc}, 32'h0000);
        chk("wrap.pc_outcome",  {16'b0, bus.pc_outcome},  32'hFFFF);

        // correct EX branch and correct untagged ID jump in the same cycle
        step(); set_if(1'b1, 16'h0070, 16'h0071, 1'b1); set_ex(1'b0, 16'h0); settle();
        chk_pulses("c17", 0, 0, 0, 0, 0);
        chk_stats("c17", 5, 4);

        step(); set_if(1'b1, 16'h0071, 16'h0090, 1'b0); set_id(1'b1, 1'b0, 1'b0, 16'h0075); settle();
        chk_pulses("c18", 0, 0, 0, 0, 0);

        step(); set_id(1'b0, 1'b1, 1'b0, 16'h0090); set_ex(1'b0, 16'h0075); set_if(1'b1, 16'h0090, 16'h0091, 1'b0); settle();
        chk_pulses("dual", 1, 1, 0, 0, 0);
        chk("dual.pc_collided",    {16'b0, bus.pc_collided},    32'h0071);
        chk("dual.branch_target",  {16'b0, bus.branch_target},  32'h0090);
        chk("dual.pc_outcome",     {16'b0, bus.pc_outcome},     32'h0070);
        chk("dual.branch_outcome", {31'b0, bus.branch_outcome}, 32'h0);

        // reset arriving while an untagged jump sits in ID
        step(); reset = 1'b1; set_id(1'b0, 1'b1, 1'b0, 16'h00A0); set_if(1'b0, 16'h0, 16'h0, 1'b0); set_ex(1'b0, 16'h0); settle();
        chk_pulses("reset_mid", 0, 0, 0, 0, 0);
        chk_stats("before_reset", 7, 4);

        step(); reset = 1'b0; settle();
        chk_pulses("after_reset", 0, 0, 0, 0, 0);
        chk_stats("after_reset", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
